// File: rtl/trigger_conditioner.sv
// trigger_conditioner
// Conditions the raw light-gun trigger switch into a clean gunShot level:
// two-stage synchroniser, debounce on both edges, minimum high time,
// post-release cooldown and a one-cycle fire_pulse per accepted shot.
// The single timer counts consecutive matching samples in the debounce
// states, time-in-state in S_FIRE and S_COOL, and saturates at all-ones.

module trigger_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int MIN_HIGH_CYCLES = 4,
  parameter int COOLDOWN_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic trigger_raw,
  input  logic enable,
  output logic gunShot,
  output logic fire_pulse,
  output logic busy
);

  typedef enum logic [2:0] {
    S_ARM     = 3'd0,
    S_IDLE    = 3'd1,
    S_PRESS   = 3'd2,
    S_FIRE    = 3'd3,
    S_RELEASE = 3'd4,
    S_COOL    = 3'd5
  } state_t;

  // Timer value on the edge that sees the last required debounce sample.
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_HIGH  = CNT_W'(MIN_HIGH_CYCLES);
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] T_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] T_MAX     = {CNT_W{1'b1}};

  logic             trig_meta_r;
  logic             t_s;
  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] timer_r;
  logic [CNT_W-1:0] timer_nxt_s;
  logic [CNT_W-1:0] timer_inc_s;
  logic             min_met_r;
  logic             min_met_nxt_s;
  logic             pulse_nxt_s;
  logic             gun_shot_r;
  logic             fire_pulse_r;
  logic             busy_r;

  assign gunShot    = gun_shot_r;
  assign fire_pulse = fire_pulse_r;
  assign busy       = busy_r;

  // Saturating increment: a long hold must never wrap back into a compare window.
  assign timer_inc_s = (timer_r == T_MAX) ? timer_r : (timer_r + T_ONE);

  // Two-flop synchroniser for the asynchronous trigger switch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_meta_r <= 1'b0;
      t_s         <= 1'b0;
    end else begin
      trig_meta_r <= trigger_raw;
      t_s         <= trig_meta_r;
    end
  end

  // Next-state, timer and strobe decisions; every path starts from defaults.
  always_comb begin
    state_nxt_s   = state_r;
    timer_nxt_s   = timer_inc_s;
    min_met_nxt_s = min_met_r;
    pulse_nxt_s   = 1'b0;
    case (state_r)
      S_ARM: begin
        // A trigger held through reset or disable must be seen released first.
        if (t_s) begin
          timer_nxt_s = T_ZERO;
        end else if (timer_r >= DEB_LAST) begin
          state_nxt_s = S_IDLE;
          timer_nxt_s = T_ZERO;
        end else begin
          timer_nxt_s = timer_inc_s;
        end
      end
      S_IDLE: begin
        timer_nxt_s = T_ZERO;
        if (!enable) begin
          state_nxt_s = S_ARM;
        end else if (t_s) begin
          // This edge already counts as the first stable high sample.
          if (DEB_LAST == T_ZERO) begin
            state_nxt_s   = S_FIRE;
            pulse_nxt_s   = 1'b1;
            min_met_nxt_s = 1'b0;
          end else begin
            state_nxt_s = S_PRESS;
            timer_nxt_s = T_ONE;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_PRESS: begin
        if (!enable) begin
          state_nxt_s = S_ARM;
          timer_nxt_s = T_ZERO;
        end else if (!t_s) begin
          state_nxt_s = S_IDLE;
          timer_nxt_s = T_ZERO;
        end else if (timer_r >= DEB_LAST) begin
          state_nxt_s   = S_FIRE;
          timer_nxt_s   = T_ZERO;
          pulse_nxt_s   = 1'b1;
          min_met_nxt_s = 1'b0;
        end else begin
          timer_nxt_s = timer_inc_s;
        end
      end
      S_FIRE: begin
        // min_met_r covers re-entry from a release bounce, where the timer restarted.
        if (!t_s && (min_met_r || (timer_r >= MIN_HIGH))) begin
          min_met_nxt_s = 1'b1;
          if (DEB_LAST == T_ZERO) begin
            state_nxt_s = S_COOL;
            timer_nxt_s = T_ZERO;
          end else begin
            state_nxt_s = S_RELEASE;
            timer_nxt_s = T_ONE;
          end
        end else begin
          timer_nxt_s = timer_inc_s;
        end
      end
      S_RELEASE: begin
        if (t_s) begin
          state_nxt_s = S_FIRE;
          timer_nxt_s = T_ZERO;
        end else if (timer_r >= DEB_LAST) begin
          state_nxt_s = S_COOL;
          timer_nxt_s = T_ZERO;
        end else begin
          timer_nxt_s = timer_inc_s;
        end
      end
      S_COOL: begin
        if (timer_r >= COOL_LAST) begin
          state_nxt_s = S_ARM;
          timer_nxt_s = T_ZERO;
        end else begin
          timer_nxt_s = timer_inc_s;
        end
      end
      default: begin
        state_nxt_s   = S_ARM;
        timer_nxt_s   = T_ZERO;
        min_met_nxt_s = 1'b0;
      end
    endcase
  end

  // State, timer and registered outputs derived from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= S_ARM;
      timer_r      <= T_ZERO;
      min_met_r    <= 1'b0;
      gun_shot_r   <= 1'b0;
      fire_pulse_r <= 1'b0;
      busy_r       <= 1'b1;
    end else begin
      state_r      <= state_nxt_s;
      timer_r      <= timer_nxt_s;
      min_met_r    <= min_met_nxt_s;
      gun_shot_r   <= (state_nxt_s == S_FIRE) || (state_nxt_s == S_RELEASE);
      fire_pulse_r <= pulse_nxt_s;
      busy_r       <= (state_nxt_s != S_IDLE);
    end
  end

endmodule

// File: tb/tb_trigger_conditioner.sv
// Testbench for trigger_conditioner (DEBOUNCE=4, MIN_HIGH=3, COOLDOWN=5).
// Reference model tracks run lengths of synchronised samples and a coarse
// mode (arming / ready / shot / cooling), compared every cycle.

module tb_trigger_conditioner;

  localparam int D  = 4;
  localparam int MH = 3;
  localparam int CD = 5;

  logic clk;
  logic reset;
  logic trigger_raw;
  logic enable;
  logic gunShot;
  logic fire_pulse;
  logic busy;

  int n_cmp;
  int n_bad;
  int dut_pulses;
  int dut_falls;
  logic prev_gun;

  typedef enum {M_ARMING, M_READY, M_SHOT, M_COOLING} mode_t;
  mode_t m_mode;
  bit    m_s1, m_s2;
  int    arm_lo, press_hi, rel_lo, age, cool_cnt;
  bit    m_gun, m_pulse, m_busy;

  trigger_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .MIN_HIGH_CYCLES(MH),
    .COOLDOWN_CYCLES(CD),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .trigger_raw(trigger_raw),
    .enable(enable),
    .gunShot(gunShot),
    .fire_pulse(fire_pulse),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = M_ARMING;
    m_s1 = 1'b0; m_s2 = 1'b0;
    arm_lo = 0; press_hi = 0; rel_lo = 0; age = 0; cool_cnt = 0;
    m_gun = 1'b0; m_pulse = 1'b0; m_busy = 1'b1;
  endfunction

  function automatic void model_edge(input bit raw, input bit en);
    bit ts;
    ts = m_s2;
    m_pulse = 1'b0;
    case (m_mode)
      M_ARMING: begin
        if (!ts) arm_lo++; else arm_lo = 0;
        if (arm_lo == D) begin m_mode = M_READY; press_hi = 0; end
      end
      M_READY: begin
        if (!en) begin
          m_mode = M_ARMING; arm_lo = 0; press_hi = 0;
        end else if (ts) begin
          press_hi++;
          if (press_hi == D) begin
            m_mode = M_SHOT; m_gun = 1'b1; m_pulse = 1'b1; age = 0; rel_lo = 0;
          end
        end else begin
          press_hi = 0;
        end
      end
      M_SHOT: begin
        if (ts) rel_lo = 0;
        else if (rel_lo > 0 || age >= MH) rel_lo++;
        age++;
        if (rel_lo == D) begin m_mode = M_COOLING; m_gun = 1'b0; cool_cnt = 0; end
      end
      M_COOLING: begin
        cool_cnt++;
        if (cool_cnt == CD) begin m_mode = M_ARMING; arm_lo = 0; end
      end
      default: m_mode = M_ARMING;
    endcase
    m_s2 = m_s1;
    m_s1 = raw;
    m_busy = !(m_mode == M_READY && press_hi == 0);
  endfunction

  // One clock edge: advance the model, then compare just after the edge.
  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge(trigger_raw, enable);
    #1;
    check_eq("gunShot", gunShot, m_gun);
    check_eq("fire_pulse", fire_pulse, m_pulse);
    check_eq("busy", busy, m_busy);
    if (fire_pulse) dut_pulses++;
    if (prev_gun && !gunShot) dut_falls++;
    prev_gun = gunShot;
  endtask

  task automatic hold(input logic v, input int n);
    trigger_raw = v;
    repeat (n) tick();
  endtask

  initial begin
    int p0, f0, rise_at, fall_at, lvl, len;
    n_cmp = 0; n_bad = 0; dut_pulses = 0; dut_falls = 0; prev_gun = 1'b0;
    reset = 1'b1; trigger_raw = 1'b0; enable = 1'b1;
    model_reset();
    #2;
    check_eq("rst_gun", gunShot, 1'b0);
    check_eq("rst_pulse", fire_pulse, 1'b0);
    check_eq("rst_busy", busy, 1'b1);
    tick(); tick();
    reset = 1'b0;
    hold(1'b0, 8);
    check_eq("armed_idle_busy", busy, 1'b0);

    // 1: clean press, rise latency 1+D, release latency 1+D
    p0 = dut_pulses;
    trigger_raw = 1'b1;
    rise_at = -1;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (gunShot && rise_at < 0) begin
        rise_at = n;
        check_eq("s1_pulse_at_rise", fire_pulse, 1'b1);
      end
    end
    check_eq("s1_rise_edge", rise_at, 1 + D);
    hold(1'b1, 8);
    trigger_raw = 1'b0;
    fall_at = -1;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (!gunShot && fall_at < 0) fall_at = n;
    end
    check_eq("s1_fall_edge", fall_at, 1 + D);
    hold(1'b0, 15);
    check_eq("s1_pulses", dut_pulses - p0, 1);

    // 2: bouncy press
    p0 = dut_pulses;
    hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 1); hold(1'b0, 1);
    trigger_raw = 1'b1;
    rise_at = -1;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (gunShot && rise_at < 0) rise_at = n;
    end
    check_eq("s2_rise_edge", rise_at, 1 + D);
    hold(1'b1, 5);
    hold(1'b0, 25);
    check_eq("s2_pulses", dut_pulses - p0, 1);

    // 3: bounce on release
    p0 = dut_pulses; f0 = dut_falls;
    hold(1'b1, 14);
    hold(1'b0, 2); hold(1'b1, 1);
    check_eq("s3_still_high", gunShot, 1'b1);
    hold(1'b0, 25);
    check_eq("s3_falls", dut_falls - f0, 1);
    check_eq("s3_pulses", dut_pulses - p0, 1);

    // 4: press during cooldown ignored, later press accepted
    hold(1'b1, 14);
    trigger_raw = 1'b0;
    for (int n = 0; n < 20 && gunShot; n++) tick();
    check_eq("s4_fall_seen", gunShot, 1'b0);
    p0 = dut_pulses;
    hold(1'b0, 2);
    hold(1'b1, 3);
    hold(1'b0, 20);
    check_eq("s4_cool_pulses", dut_pulses - p0, 0);
    p0 = dut_pulses;
    hold(1'b1, 12);
    hold(1'b0, 20);
    check_eq("s4_new_shot", dut_pulses - p0, 1);

    // 5: trigger held through reset
    p0 = dut_pulses;
    trigger_raw = 1'b1;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    hold(1'b1, 30);
    check_eq("s5_held_pulses", dut_pulses - p0, 0);
    check_eq("s5_held_gun", gunShot, 1'b0);
    hold(1'b0, 10);
    hold(1'b1, 10);
    hold(1'b0, 20);
    check_eq("s5_after_release", dut_pulses - p0, 1);

    // 6a: disable during debounce of a press
    p0 = dut_pulses;
    hold(1'b1, 3);
    enable = 1'b0;
    tick();
    check_eq("s6_busy", busy, 1'b1);
    hold(1'b1, 6);
    enable = 1'b1;
    hold(1'b0, 10);
    check_eq("s6_no_shot", dut_pulses - p0, 0);

    // 6b: async reset in the middle of a shot
    hold(1'b1, 8);
    check_eq("s6_in_fire", gunShot, 1'b1);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check_eq("s6_async_gun", gunShot, 1'b0);
    check_eq("s6_async_busy", busy, 1'b1);
    prev_gun = gunShot;
    tick(); tick();
    reset = 1'b0;
    hold(1'b0, 12);

    // Randomised bursts with occasional disable windows
    for (int i = 0; i < 150; i++) begin
      enable = ($urandom_range(0, 15) != 0);
      lvl = $urandom_range(0, 1);
      len = $urandom_range(1, 12);
      hold(lvl[0], len);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
